// File: rtl/alu_pkg.sv
// alu_pkg: shared types, op-code constants and overflow helpers for the RV32I execute datapath.
`default_nettype none

package alu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [3:0] {
      IT_R      = 4'd0,
      IT_I      = 4'd1,
      IT_LOAD   = 4'd2,
      IT_STORE  = 4'd3,
      IT_BRANCH = 4'd4,
      IT_JALR   = 4'd5,
      IT_JAL    = 4'd6,
      IT_AUIPC  = 4'd7,
      IT_LUI    = 4'd8
   } input_type_e;

   // R-type codes; I-type codes are remapped onto these in the top.
   localparam logic [3:0] R_ADD  = 4'd0;
   localparam logic [3:0] R_SUB  = 4'd1;
   localparam logic [3:0] R_SLL  = 4'd2;
   localparam logic [3:0] R_SLT  = 4'd3;
   localparam logic [3:0] R_SLTU = 4'd4;
   localparam logic [3:0] R_XOR  = 4'd5;
   localparam logic [3:0] R_SRL  = 4'd6;
   localparam logic [3:0] R_SRA  = 4'd7;
   localparam logic [3:0] R_OR   = 4'd8;
   localparam logic [3:0] R_AND  = 4'd9;
   localparam logic [3:0] R_NONE = 4'd15;

   localparam logic [3:0] I_ADDI  = 4'd0;
   localparam logic [3:0] I_ANDI  = 4'd8;

   localparam logic [3:0] LD_LB  = 4'd0;
   localparam logic [3:0] LD_LH  = 4'd1;
   localparam logic [3:0] LD_LW  = 4'd2;
   localparam logic [3:0] LD_LBU = 4'd3;
   localparam logic [3:0] LD_LHU = 4'd4;

   localparam logic [3:0] ST_SB = 4'd0;
   localparam logic [3:0] ST_SH = 4'd1;
   localparam logic [3:0] ST_SW = 4'd2;

   localparam logic [3:0] BR_BEQ  = 4'd0;
   localparam logic [3:0] BR_BNE  = 4'd1;
   localparam logic [3:0] BR_BLT  = 4'd4;
   localparam logic [3:0] BR_BGE  = 4'd6;
   localparam logic [3:0] BR_BLTU = 4'd7;
   localparam logic [3:0] BR_BGEU = 4'd8;

   function automatic logic add_ovf(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                    input logic [XLEN-1:0] s);
      return (a[XLEN-1] == b[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]);
   endfunction

   function automatic logic sub_ovf(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                    input logic [XLEN-1:0] d);
      return (a[XLEN-1] != b[XLEN-1]) && (d[XLEN-1] != a[XLEN-1]);
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mem_lane.sv
// alu_mem_lane: load byte/halfword extraction with extension, store lane shifting and byte mask.
`default_nettype none

module alu_mem_lane
   import alu_pkg::*;
(
   input  logic [1:0]      addr,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] rdata,
   input  logic [XLEN-1:0] wsrc,
   output logic [XLEN-1:0] load_data,
   output logic            load_ok,
   output logic [XLEN-1:0] store_data,
   output logic [3:0]      store_mask,
   output logic            store_ok
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      load_ok   = 1'b1;
      load_data = '0;
      case (op)
         LD_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
         LD_LH:   load_data = {{16{half_sel[15]}}, half_sel};
         LD_LW:   load_data = rdata;
         LD_LBU:  load_data = {24'd0, byte_sel};
         LD_LHU:  load_data = {16'd0, half_sel};
         default: load_ok   = 1'b0;
      endcase
   end

   always_comb begin
      store_ok   = 1'b1;
      store_data = '0;
      store_mask = 4'b0000;
      case (op)
         ST_SB: begin
            store_data = {24'd0, wsrc[7:0]} << {addr, 3'b000};
            store_mask = 4'b0001 << addr;
         end
         ST_SH: begin
            store_data = addr[1] ? {wsrc[15:0], 16'd0} : {16'd0, wsrc[15:0]};
            store_mask = addr[1] ? 4'b1100 : 4'b0011;
         end
         ST_SW: begin
            store_data = wsrc;
            store_mask = 4'b1111;
         end
         default: store_ok = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/alu.sv
// alu: single-cycle RV32I execute/memory datapath with registered zero/negative/overflow flags.
// Optional macro ALU_MISALIGN_TRAP_EN adds a 'misaligned' output that suppresses all valids.
`default_nettype none

module alu
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] read_data1,
   input  logic [XLEN-1:0] read_data2,
   input  logic [XLEN-1:0] imm,
   input  logic [3:0]      alu_control,
   input  logic [3:0]      input_type,
   input  logic [XLEN-1:0] data_read,
   input  logic [XLEN-1:0] instruction_addr,
   output logic [XLEN-1:0] reg_write_data,
   output logic [XLEN-1:0] data_write,
   output logic [3:0]      data_write_byte,
   output logic [XLEN-1:0] data_addr,
   output logic            zero_flag,
   output logic            negative_flag,
   output logic            overflow_flag,
   output logic            data_read_valid,
   output logic            data_write_valid,
   output logic            register_write_valid
`ifdef ALU_MISALIGN_TRAP_EN
   ,
   output logic            misaligned
`endif
);

   input_type_e     cls;
   logic [XLEN-1:0] op2, sum, diff, arith, mem_addr, pc_plus4, pc_plus_imm;
   logic [XLEN-1:0] load_data, store_data;
   logic [4:0]      shamt;
   logic [3:0]      op, store_mask;
   logic            arith_ok, arith_ovf, taken, load_ok, store_ok, blocked;
   logic            rd_raw, wr_raw, rw_raw;
   logic            flags_upd, zero_next, neg_next, ovf_next;

   assign cls         = input_type_e'(input_type);
   assign op2         = (cls == IT_I) ? imm : read_data2;
   assign sum         = read_data1 + op2;
   assign diff        = read_data1 - op2;
   assign shamt       = op2[4:0];
   assign mem_addr    = read_data1 + imm;
   assign pc_plus4    = instruction_addr + 32'd4;
   assign pc_plus_imm = instruction_addr + imm;

   // I-type codes 1..8 line up with R-type codes 2..9 (I has no SUB slot).
   always_comb begin
      op = R_NONE;
      if (cls == IT_R) begin
         op = alu_control;
      end else if (cls == IT_I) begin
         if (alu_control == I_ADDI)
            op = R_ADD;
         else if (alu_control <= I_ANDI)
            op = alu_control + 4'd1;
      end
   end

   always_comb begin
      arith     = '0;
      arith_ok  = 1'b1;
      arith_ovf = 1'b0;
      case (op)
         R_ADD: begin
            arith     = sum;
            arith_ovf = add_ovf(read_data1, op2, sum);
         end
         R_SUB: begin
            arith     = diff;
            arith_ovf = sub_ovf(read_data1, op2, diff);
         end
         R_SLL:   arith = read_data1 << shamt;
         R_SLT:   arith = {31'd0, $signed(read_data1) < $signed(op2)};
         R_SLTU:  arith = {31'd0, read_data1 < op2};
         R_XOR:   arith = read_data1 ^ op2;
         R_SRL:   arith = read_data1 >> shamt;
         R_SRA:   arith = $signed(read_data1) >>> shamt;
         R_OR:    arith = read_data1 | op2;
         R_AND:   arith = read_data1 & op2;
         default: arith_ok = 1'b0;
      endcase
   end

   always_comb begin
      case (alu_control)
         BR_BEQ:  taken = (diff == '0);
         BR_BNE:  taken = (diff != '0);
         BR_BLT:  taken = $signed(read_data1) <  $signed(op2);
         BR_BGE:  taken = $signed(read_data1) >= $signed(op2);
         BR_BLTU: taken = read_data1 <  op2;
         BR_BGEU: taken = read_data1 >= op2;
         default: taken = 1'b0;
      endcase
   end

   alu_mem_lane u_mem_lane (
      .addr       (mem_addr[1:0]),
      .op         (alu_control),
      .rdata      (data_read),
      .wsrc       (read_data2),
      .load_data  (load_data),
      .load_ok    (load_ok),
      .store_data (store_data),
      .store_mask (store_mask),
      .store_ok   (store_ok)
   );

   always_comb begin
      reg_write_data  = '0;
      data_write      = '0;
      data_write_byte = 4'b0000;
      data_addr       = '0;
      rd_raw          = 1'b0;
      wr_raw          = 1'b0;
      rw_raw          = 1'b0;
      case (cls)
         IT_R, IT_I: begin
            reg_write_data = arith;
            rw_raw         = arith_ok;
         end
         IT_LOAD: begin
            data_addr      = mem_addr;
            reg_write_data = load_data;
            rd_raw         = load_ok;
            rw_raw         = load_ok;
         end
         IT_STORE: begin
            data_addr       = mem_addr;
            data_write      = store_data;
            data_write_byte = store_mask;
            wr_raw          = store_ok;
         end
         IT_BRANCH: reg_write_data = taken ? pc_plus_imm : pc_plus4;
         IT_JALR, IT_JAL: begin
            reg_write_data = pc_plus4;
            rw_raw         = 1'b1;
         end
         IT_AUIPC: begin
            reg_write_data = pc_plus_imm;
            rw_raw         = 1'b1;
         end
         IT_LUI: begin
            reg_write_data = imm;
            rw_raw         = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef ALU_MISALIGN_TRAP_EN
   always_comb begin
      misaligned = 1'b0;
      if (cls == IT_LOAD) begin
         if ((alu_control == LD_LH || alu_control == LD_LHU) && mem_addr[0])
            misaligned = 1'b1;
         if (alu_control == LD_LW && mem_addr[1:0] != 2'b00)
            misaligned = 1'b1;
      end else if (cls == IT_STORE) begin
         if (alu_control == ST_SH && mem_addr[0])
            misaligned = 1'b1;
         if (alu_control == ST_SW && mem_addr[1:0] != 2'b00)
            misaligned = 1'b1;
      end
   end
   assign blocked = misaligned;
`else
   assign blocked = 1'b0;
`endif

   assign data_read_valid      = rd_raw & ~reset & ~blocked;
   assign data_write_valid     = wr_raw & ~reset & ~blocked;
   assign register_write_valid = rw_raw & ~reset & ~blocked;

   // Branch flags come from rs1-rs2, which is 'diff' because op2 is rs2 outside I-type.
   always_comb begin
      flags_upd = 1'b0;
      zero_next = 1'b0;
      neg_next  = 1'b0;
      ovf_next  = 1'b0;
      case (cls)
         IT_R, IT_I: begin
            flags_upd = 1'b1;
            zero_next = (arith == '0);
            neg_next  = arith[XLEN-1];
            ovf_next  = arith_ovf;
         end
         IT_BRANCH: begin
            flags_upd = 1'b1;
            zero_next = (diff == '0);
            neg_next  = diff[XLEN-1];
            ovf_next  = sub_ovf(read_data1, op2, diff);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         zero_flag     <= 1'b0;
         negative_flag <= 1'b0;
         overflow_flag <= 1'b0;
      end else if (flags_upd) begin
         zero_flag     <= zero_next;
         negative_flag <= neg_next;
         overflow_flag <= ovf_next;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for the alu execute datapath.
`default_nettype none

module tb_alu;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] read_data1, read_data2, imm, data_read, instruction_addr;
   logic [3:0]  alu_control, input_type;
   logic [31:0] reg_write_data, data_write, data_addr;
   logic [3:0]  data_write_byte;
   logic        zero_flag, negative_flag, overflow_flag;
   logic        data_read_valid, data_write_valid, register_write_valid;
`ifdef ALU_MISALIGN_TRAP_EN
   logic        misaligned;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu dut (
      .clk                  (clk),
      .reset                (reset),
      .read_data1           (read_data1),
      .read_data2           (read_data2),
      .imm                  (imm),
      .alu_control          (alu_control),
      .input_type           (input_type),
      .data_read            (data_read),
      .instruction_addr     (instruction_addr),
      .reg_write_data       (reg_write_data),
      .data_write           (data_write),
      .data_write_byte      (data_write_byte),
      .data_addr            (data_addr),
      .zero_flag            (zero_flag),
      .negative_flag        (negative_flag),
      .overflow_flag        (overflow_flag),
      .data_read_valid      (data_read_valid),
      .data_write_valid     (data_write_valid),
      .register_write_valid (register_write_valid)
`ifdef ALU_MISALIGN_TRAP_EN
      ,
      .misaligned           (misaligned)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Apply a new vector just after the falling edge, then let it settle.
   task automatic drive(input logic [3:0] t, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] i);
      @(negedge clk);
      input_type  = t;
      alu_control = c;
      read_data1  = a;
      read_data2  = b;
      imm         = i;
      #1;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      input_type = 4'd0; alu_control = 4'd0;
      read_data1 = 32'd11; read_data2 = 32'd22; imm = 32'd0;
      data_read = 32'd0; instruction_addr = 32'h100;
      #12;
      chk("reset_rwv", register_write_valid, 0);
      chk("reset_zero", zero_flag, 0);
      chk("reset_neg", negative_flag, 0);
      chk("reset_ovf", overflow_flag, 0);
      @(negedge clk);
      reset = 1'b0;

      // R-type arithmetic and flags
      drive(4'd0, 4'd0, 32'd11, 32'd22, 32'd0);
      chk("add_res", reg_write_data, 32'd33);
      chk("add_rwv", register_write_valid, 1);
      after_edge();
      chk("add_zero", zero_flag, 0);
      chk("add_neg", negative_flag, 0);

      drive(4'd0, 4'd1, 32'd11, 32'd22, 32'd0);
      chk("sub_res", reg_write_data, 32'hFFFF_FFF5);
      after_edge();
      chk("sub_neg", negative_flag, 1);
      chk("sub_ovf0", overflow_flag, 0);

      drive(4'd0, 4'd1, 32'h8000_0000, 32'd1, 32'd0);
      chk("subov_res", reg_write_data, 32'h7FFF_FFFF);
      after_edge();
      chk("subov_ovf", overflow_flag, 1);
      chk("subov_neg", negative_flag, 0);

      // I-type: imm must be used, not rs2
      drive(4'd1, 4'd6, 32'h8000_0000, 32'd1, 32'h0000_0405);
      chk("srai_res", reg_write_data, 32'hFC00_0000);
      after_edge();
      chk("srai_neg", negative_flag, 1);
      chk("srai_ovf", overflow_flag, 0);

      drive(4'd1, 4'd3, 32'd11, 32'd0, 32'hFFFF_FFFF);
      chk("sltiu_res", reg_write_data, 32'd1);
      chk("sltiu_rwv", register_write_valid, 1);

      drive(4'd0, 4'd12, 32'd11, 32'd22, 32'd0);
      chk("rundef_res", reg_write_data, 32'd0);
      chk("rundef_rwv", register_write_valid, 0);
      after_edge();
      chk("rundef_zero", zero_flag, 1);

      // Loads
      data_read = 32'h0000_00F4;
      drive(4'd2, 4'd0, 32'd11, 32'd0, 32'd5);
      chk("lb_addr", data_addr, 32'd16);
      chk("lb_res", reg_write_data, 32'hFFFF_FFF4);
      chk("lb_drv", data_read_valid, 1);
      chk("lb_rwv", register_write_valid, 1);
      after_edge();
      chk("load_hold_zero", zero_flag, 1);

      drive(4'd2, 4'd3, 32'd11, 32'd0, 32'd5);
      chk("lbu_res", reg_write_data, 32'h0000_00F4);

      data_read = 32'h8001_00F4;
      drive(4'd2, 4'd1, 32'd11, 32'd0, 32'd7);
      chk("lh_hi_res", reg_write_data, 32'hFFFF_8001);
      drive(4'd2, 4'd4, 32'd11, 32'd0, 32'd7);
      chk("lhu_hi_res", reg_write_data, 32'h0000_8001);
      drive(4'd2, 4'd2, 32'd11, 32'd0, 32'd5);
      chk("lw_res", reg_write_data, 32'h8001_00F4);

      // Stores
      drive(4'd3, 4'd0, 32'd11, 32'd22, 32'd6);
      chk("sb_addr", data_addr, 32'd17);
      chk("sb_mask", data_write_byte, 32'b0010);
      chk("sb_data", data_write, 32'h0000_1600);
      chk("sb_dwv", data_write_valid, 1);
      chk("sb_rwv", register_write_valid, 0);
      chk("sb_drv", data_read_valid, 0);

      drive(4'd3, 4'd1, 32'd11, 32'h1234_ABCD, 32'd7);
      chk("sh_data", data_write, 32'hABCD_0000);
      chk("sh_mask", data_write_byte, 32'b1100);
      drive(4'd3, 4'd2, 32'd11, 32'h1234_ABCD, 32'd5);
      chk("sw_data", data_write, 32'h1234_ABCD);
      chk("sw_mask", data_write_byte, 32'b1111);

      // Branches and jumps, PC=0x100, imm=0x20
      drive(4'd4, 4'd0, 32'd11, 32'd11, 32'h20);
      chk("beq_res", reg_write_data, 32'h120);
      chk("beq_rwv", register_write_valid, 0);
      after_edge();
      chk("beq_zero", zero_flag, 1);
      drive(4'd4, 4'd1, 32'd11, 32'd11, 32'h20);
      chk("bne_res", reg_write_data, 32'h104);
      drive(4'd4, 4'd4, 32'hFFFF_FFFF, 32'd1, 32'h20);
      chk("blt_res", reg_write_data, 32'h120);
      drive(4'd4, 4'd7, 32'hFFFF_FFFF, 32'd1, 32'h20);
      chk("bltu_res", reg_write_data, 32'h104);
      drive(4'd4, 4'd2, 32'd5, 32'd5, 32'h20);
      chk("bundef_res", reg_write_data, 32'h104);
      drive(4'd4, 4'd6, 32'd5, 32'd7, 32'h20);
      chk("bge_res", reg_write_data, 32'h104);
      after_edge();
      chk("br_neg", negative_flag, 1);
      chk("br_zero", zero_flag, 0);

      drive(4'd6, 4'd0, 32'd0, 32'd0, 32'h20);
      chk("jal_res", reg_write_data, 32'h104);
      chk("jal_rwv", register_write_valid, 1);
      drive(4'd7, 4'd0, 32'd0, 32'd0, 32'h20);
      chk("auipc_res", reg_write_data, 32'h120);
      drive(4'd8, 4'd0, 32'd0, 32'd0, 32'h1234_5000);
      chk("lui_res", reg_write_data, 32'h1234_5000);
      drive(4'd9, 4'd0, 32'd11, 32'd22, 32'd5);
      chk("t9_res", reg_write_data, 32'd0);
      chk("t9_addr", data_addr, 32'd0);
      chk("t9_rwv", register_write_valid, 0);

      // Asynchronous reset clears flags with no clock edge
      drive(4'd0, 4'd1, 32'd11, 32'd22, 32'd0);
      after_edge();
      chk("pre_rst_neg", negative_flag, 1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("async_rst_neg", negative_flag, 0);
      chk("async_rst_zero", zero_flag, 0);
      chk("async_rst_rwv", register_write_valid, 0);
      #1;
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu.md
Name: alu

Overview:
- Execute/memory-access datapath of the single-cycle RV32I core.
- Driven by the control decoder, which supplies the operands, the sign-extended immediate, the current PC, an instruction class (input_type) and a per-class operation code (alu_control).
- Produces the register write-back value, load/store address, store data and byte mask, and the three handshake valids.
- Also produces registered zero/negative/overflow status flags.

Parameters:
- None. Width is fixed at 32 bits.

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  asynchronous reset, active-high.
- read_data1  in  32  rs1 value.
- read_data2  in  32  rs2 value.
- imm  in  32  immediate, already sign-extended and positioned by the decoder.
- alu_control  in  4  operation code within the class.
- input_type  in  4  instruction class: 0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JALR, 6 JAL, 7 AUIPC, 8 LUI.
- data_read  in  32  word returned by data memory.
- instruction_addr  in  32  PC of the current instruction.
- reg_write_data  out  32  write-back value; for BRANCH, the next PC.
- data_write  out  32  store data, lane-aligned.
- data_write_byte  out  4  store byte-enable mask.
- data_addr  out  32  load/store address.
- zero_flag  out  1  registered status flag.
- negative_flag  out  1  registered status flag.
- overflow_flag  out  1  registered status flag.
- data_read_valid  out  1  load request.
- data_write_valid  out  1  store request.
- register_write_valid  out  1  write-back enable.

Behaviour:
- All outputs except the flags are combinational from the current inputs.
- Default value of every combinational output is 0.
- While reset is high, all three valids are forced to 0.
- R-type alu_control: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND. Operands are rs1 and rs2.
- I-type alu_control: 0 ADDI, 1 SLLI, 2 SLTI, 3 SLTIU, 4 XORI, 5 SRLI, 6 SRAI, 7 ORI, 8 ANDI. Operands are rs1 and imm.
- Shift amount is operand2[4:0]. SLT/SLTU results are 0 or 1. Arithmetic wraps modulo 2^32.
- R and I types assert register_write_valid for a defined code. An undefined code gives result 0 and register_write_valid 0.
- LOAD/STORE address: data_addr = rs1 + imm.
- LOAD alu_control: 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU.
  - Byte lane is data_addr[1:0]; halfword lane is data_addr[1]; LW ignores the low bits.
  - Byte/halfword results are sign- or zero-extended per the opcode.
  - Asserts data_read_valid and register_write_valid.
- STORE alu_control: 0 SB, 1 SH, 2 SW.
  - data_write is rs2 shifted into its lane.
  - Masks: SB 0001<<addr[1:0]; SH 0011 or 1100 per addr[1]; SW 1111.
  - Asserts data_write_valid only.
- BRANCH alu_control: 0 BEQ, 1 BNE, 4 BLT, 6 BGE, 7 BLTU, 8 BGEU.
  - reg_write_data = taken ? PC+imm : PC+4. No valids asserted.
  - An undefined code is treated as not taken.
- JALR and JAL: reg_write_data = PC+4; register_write_valid=1.
- AUIPC: reg_write_data = PC+imm; register_write_valid=1.
- LUI: reg_write_data = imm; register_write_valid=1.
- input_type 9–15: all outputs 0.
- Flags:
  - Updated on the rising clk edge only when input_type is R, I or BRANCH; otherwise they hold.
  - R/I: zero = result==0, negative = result[31], overflow = signed overflow of ADD/ADDI/SUB, otherwise 0.
  - BRANCH: flags are computed from rs1-rs2.
  - Reset clears all three flags to 0 immediately, including mid-operation.

Optional Feature:
- Macro ALU_MISALIGN_TRAP_EN.
- When defined: adds output port misaligned (1 bit). It is asserted combinationally when LH/LHU/SH have addr[0]=1, or LW/SW have addr[1:0]≠0. While asserted, data_read_valid, data_write_valid and register_write_valid are forced to 0.
- When undefined: no port; misaligned accesses proceed with the lane selection rules above.

Decomposition:
- Package alu_pkg holds:
  - the input_type enum (R..LUI);
  - per-class op-code localparams (R, I, LOAD, STORE, BRANCH);
  - the XLEN=32 constant.
- One sub-module alu_mem_lane:
  - load byte/halfword extraction with extension;
  - store lane shifting and byte-mask generation.

Test Plan:
- R ADD, rs1=11, rs2=22 -> reg_write_data=33, register_write_valid=1. After the edge: zero=0, negative=0.
- R SUB 11-22 -> 0xFFFFFFF5, negative=1 after the edge. SUB 0x80000000-1 -> 0x7FFFFFFF, overflow=1.
- I SRAI, rs1=0x80000000, imm=0x405 -> 0xFC000000. SLTIU, rs1=11, imm=-1 -> 1.
- LOAD, rs1=11, imm=5, data_read=0x0000_00F4:
  - data_addr=16, data_read_valid=1;
  - LB -> 0xFFFFFFF4; LBU -> 0x000000F4.
- STORE SB, rs1=11, imm=6, rs2=22 -> data_addr=17, data_write_byte=0010, data_write=0x00001600, data_write_valid=1, register_write_valid=0.
- BRANCH/jumps with PC=0x100, imm=0x20:
  - BEQ rs1=rs2=11 -> 0x120; BNE -> 0x104;
  - JAL -> 0x104 with register_write_valid=1;
  - assert reset mid-sequence -> flags 0 at once, no clock needed.
